apb_strb_mem: RTL

APB4 word-addressed memory slave, parametrised in data width, depth and wait states. It is the successor to the basic zero-wait `apb_mem` and adds:
- byte-lane write strobes (`pstrb`),
- a programmable wait-state counter driving `pready`,
- `pslverr` for out-of-range or misaligned accesses.

It sits on the peripheral APB segment as scratch RAM and is the first slave to exercise `pready` back-pressure and error responses.

---
 rtl/apb_mem_pkg.sv | 27 ++
 rtl/apb_mem_array.sv | 43 ++++
 rtl/apb_strb_mem.sv | 114 +++++++++++
 3 files changed

// File: rtl/apb_mem_pkg.sv
// Shared types and helpers for the APB strobed scratch memory.
package apb_mem_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

    localparam int WAIT_W = 4;

    // Lanes beyond the caller's bus width are ignored once the result is truncated.
    function automatic logic [63:0] strb_merge(
        input logic [63:0] old_dat,
        input logic [63:0] new_dat,
        input logic [7:0]  strb
    );
        logic [63:0] res;
        res = old_dat;
        for (int i = 0; i < 8; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_dat[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/apb_mem_array.sv
// Word storage: byte-enable synchronous write, registered read port that can be forced to zero.
// Latency: write commits on the enabled edge; read data registered one edge after rd_en.
// Backpressure: none, every request is taken on the edge it is presented.
module apb_mem_array
    import apb_mem_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 256,
    localparam int NBYTES     = DATA_WIDTH / 8,
    localparam int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  pclk,
    input  logic                  PRESETn,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [DATA_WIDTH-1:0] wr_dat,
    input  logic [NBYTES-1:0]     wr_strb,
    input  logic                  rd_en,
    input  logic                  rd_clr,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [DATA_WIDTH-1:0] rd_dat
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage deliberately has no reset so contents survive a bus reset.
    always_ff @(posedge pclk) begin
        if (wr_en) begin
            mem[wr_idx] <= DATA_WIDTH'(strb_merge(64'(mem[wr_idx]), 64'(wr_dat), 8'(wr_strb)));
        end
    end

    always_ff @(posedge pclk or negedge PRESETn) begin
        if (!PRESETn) begin
            rd_dat <= '0;
        end else if (rd_clr) begin
            rd_dat <= '0;
        end else if (rd_en) begin
            rd_dat <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/apb_strb_mem.sv
// APB4 scratch RAM slave with byte strobes, programmable wait states and error response.
// Latency: 2 + WAIT_STATES cycles from setup to completing edge; read data registered at setup.
// Backpressure: pready held low while the wait counter runs; dropping psel aborts the transfer.
module apb_strb_mem
    import apb_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                    pclk,
    input  logic                    PRESETn,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic                    pwrite,
    input  logic                    psel,
    input  logic                    penable,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pready,
    output logic                    pslverr
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int OFFS_W = $clog2(NBYTES);
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    apb_state_e        state_q, state_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              write_q;
    logic [IDX_W-1:0]  idx_q;

    logic [ADDR_WIDTH-1:0] word_addr;
    logic                  addr_err;
    logic                  setup_fire;
    logic                  done;
    logic                  wr_en;

    assign word_addr = paddr >> OFFS_W;
    assign addr_err  = (64'(word_addr) >= 64'(DEPTH))
                    || ((paddr & ADDR_WIDTH'(NBYTES - 1)) != '0);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        setup_fire = 1'b0;
        done       = 1'b0;
        case (state_q)
            IDLE: begin
                if (psel && !penable) begin
                    state_d    = ACCESS;
                    cnt_d      = WAIT_W'(WAIT_STATES);
                    err_d      = addr_err;
                    setup_fire = 1'b1;
                end
            end
            ACCESS: begin
                if (!psel) begin
                    state_d = IDLE;
                end else if (penable) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - WAIT_W'(1);
                    end else begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pready  = done;
    assign pslverr = done & err_q;
    assign wr_en   = done & write_q & ~err_q;

    always_ff @(posedge pclk or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            write_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            if (setup_fire) begin
                write_q <= pwrite;
                idx_q   <= IDX_W'(word_addr);
            end
        end
    end

    apb_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_array (
        .pclk    (pclk),
        .PRESETn (PRESETn),
        .wr_en   (wr_en),
        .wr_idx  (idx_q),
        .wr_dat  (pwdata),
        .wr_strb (pstrb),
        .rd_en   (setup_fire & ~pwrite & ~addr_err),
        .rd_clr  (setup_fire & ~pwrite & addr_err),
        .rd_idx  (IDX_W'(word_addr)),
        .rd_dat  (prdata)
    );

endmodule
